// File: rtl/jtag_scan_sequencer.sv
// Command-driven JTAG master: walks the TAP through reset, IR and DR scans on TCK
// and returns captured TDO as a response word. The TAP parks in Run-Test/Idle between commands.
`timescale 1ns/1ps
module jtag_scan_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               TCK,
    input  logic               TRST_N,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               TMS,
    output logic               TDI,
    input  logic               TDO,
    output logic               busy
);
    localparam logic [1:0] OP_DR  = 2'b00;
    localparam logic [1:0] OP_IR  = 2'b01;
    localparam logic [1:0] OP_TLR = 2'b10;

    localparam logic [3:0] S_TLR_SEQ = 4'd0;
    localparam logic [3:0] S_IDLE    = 4'd1;
    localparam logic [3:0] S_SEL_DR  = 4'd2;
    localparam logic [3:0] S_SEL_IR  = 4'd3;
    localparam logic [3:0] S_CAPTURE = 4'd4;
    localparam logic [3:0] S_SHIFT   = 4'd5;
    localparam logic [3:0] S_EXIT1   = 4'd6;
    localparam logic [3:0] S_UPDATE  = 4'd7;
    localparam logic [3:0] S_RESP    = 4'd8;

    typedef struct packed {
        logic [1:0]         op;
        logic [LEN_W-1:0]   len;
        logic [MAX_LEN-1:0] data;
    } cmd_t;

    logic [3:0]         state;
    logic [LEN_W-1:0]   cnt;
    cmd_t               cur;
    logic [MAX_LEN-1:0] cap;
    logic [LEN_W-1:0]   len_clamp;
    logic               cap_en;
    logic [LEN_W-1:0]   cap_idx;

    assign len_clamp = (cmd_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cmd_len;
    assign cmd_ready = (state == S_IDLE) && !rsp_valid;
    assign busy      = (state != S_IDLE);

    // TDO for shift bit i is sampled one edge after bit i is driven: the first
    // SHIFT edge only launches bit 0, and EXIT1 collects the final bit.
    always_comb begin
        cap_en  = 1'b0;
        cap_idx = '0;
        if (state == S_SHIFT && cnt != '0) begin
            cap_en  = 1'b1;
            cap_idx = cnt - LEN_W'(1);
        end else if (state == S_EXIT1 && cur.len != '0) begin
            cap_en  = 1'b1;
            cap_idx = cur.len - LEN_W'(1);
        end
    end

    always_ff @(posedge TCK or negedge TRST_N) begin
        if (!TRST_N) begin
            state     <= S_TLR_SEQ;
            cnt       <= '0;
            TMS       <= 1'b1;
            TDI       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            cur       <= '0;
            cap       <= '0;
        end else begin
            for (int i = 0; i < MAX_LEN; i++)
                if (cap_en && cap_idx == LEN_W'(i)) cap[i] <= TDO;

            case (state)
                // Five TMS=1 then one TMS=0; a TLR command hands off to RESP as the 0 goes out.
                S_TLR_SEQ: begin
                    if (cnt == LEN_W'(5)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else if (cnt == LEN_W'(4)) begin
                        TMS <= 1'b0;
                        if (cur.op == OP_TLR) begin
                            state <= S_RESP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + LEN_W'(1);
                        end
                    end else begin
                        TMS <= 1'b1;
                        cnt <= cnt + LEN_W'(1);
                    end
                end
                S_IDLE: begin
                    TMS <= 1'b0;
                    TDI <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        cur.op   <= cmd_op;
                        cur.len  <= len_clamp;
                        cur.data <= cmd_data;
                        cap      <= '0;
                        cnt      <= '0;
                        case (cmd_op)
                            OP_DR, OP_IR: begin
                                TMS   <= 1'b1;
                                state <= S_SEL_DR;
                            end
                            OP_TLR: begin
                                TMS   <= 1'b1;
                                state <= S_TLR_SEQ;
                            end
                            default: state <= S_RESP;
                        endcase
                    end
                end
                S_SEL_DR: begin
                    if (cur.op == OP_IR) begin
                        TMS   <= 1'b1;
                        state <= S_SEL_IR;
                    end else begin
                        TMS   <= 1'b0;
                        state <= S_CAPTURE;
                    end
                end
                S_SEL_IR: begin
                    TMS   <= 1'b0;
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    if (cur.len == '0) begin
                        TMS   <= 1'b1;
                        state <= S_EXIT1;
                    end else begin
                        TMS   <= 1'b0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    TDI      <= cur.data[0];
                    cur.data <= cur.data >> 1;
                    cnt      <= cnt + LEN_W'(1);
                    if (cnt == cur.len - LEN_W'(1)) begin
                        TMS   <= 1'b1;
                        state <= S_EXIT1;
                    end else begin
                        TMS <= 1'b0;
                    end
                end
                S_EXIT1: begin
                    TMS   <= 1'b1;
                    TDI   <= 1'b0;
                    state <= S_UPDATE;
                end
                S_UPDATE: begin
                    TMS   <= 1'b0;
                    state <= S_RESP;
                end
                S_RESP: begin
                    TMS <= 1'b0;
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_TLR_SEQ;
                    cnt   <= '0;
                    TMS   <= 1'b1;
                end
            endcase
        end
    end
endmodule
